// File: rtl/mode_sel_multi.sv
// Push-button mode selector: debounces one async button, classifies presses as short
// (advance to the next mode, wrapping) or long (return to DEF_MODE), and drives index, one-hot and change strobe.
module mode_sel_multi #(
    parameter logic C_ON        = 1'b1,
    parameter int   NUM_MODES   = 4,
    parameter int   DEF_MODE    = 0,
    parameter int   DBNC_CYCLES = 500_000,
    parameter int   LONG_CYCLES = 25_000_000,
    localparam int  MODE_W      = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_in,
    output logic [MODE_W-1:0]    mode,
    output logic [NUM_MODES-1:0] mode_oh,
    output logic                 mode_chg,
    output logic                 long_act
);

    localparam int CNT_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  DBNC_LAST = CNT_W'(DBNC_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [MODE_W-1:0] DEF_IDX   = MODE_W'(DEF_MODE);
    localparam logic [MODE_W-1:0] LAST_IDX  = MODE_W'(NUM_MODES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DB_PRESS = 3'd1;
    localparam logic [2:0] S_PRESSED  = 3'd2;
    localparam logic [2:0] S_HELD     = 3'd3;
    localparam logic [2:0] S_DB_REL   = 3'd4;

    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] idx);
        next_mode = (idx == LAST_IDX) ? '0 : idx + MODE_W'(1);
    endfunction

    function automatic logic [NUM_MODES-1:0] one_hot(input logic [MODE_W-1:0] idx);
        one_hot = NUM_MODES'(1) << idx;
    endfunction

    logic             btn_p0;
    logic             btn_p1;
    logic             pr;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_sat;
    logic             tag_long;
    logic             tag_nxt;
    logic             wr_en;
    logic [MODE_W-1:0] wr_val;

    // Stage p0/p1: two-flop synchroniser, reset to the released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_p0 <= ~C_ON;
            btn_p1 <= ~C_ON;
        end else begin
            btn_p0 <= btn_in;
            btn_p1 <= btn_p0;
        end
    end

    assign pr      = (btn_p1 == C_ON);
    assign cnt_sat = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_sat;
        tag_nxt   = tag_long;
        wr_en     = 1'b0;
        wr_val    = mode;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (pr) begin
                    state_nxt = S_DB_PRESS;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_DB_PRESS: begin
                if (!pr) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= DBNC_LAST) begin
                    state_nxt = S_PRESSED;
                    cnt_nxt   = '0;
                    tag_nxt   = 1'b0;
                end
            end
            S_PRESSED: begin
                // Release is checked first so it wins a tie with the long threshold
                if (!pr) begin
                    state_nxt = S_DB_REL;
                    cnt_nxt   = CNT_W'(1);
                    tag_nxt   = 1'b0;
                end else if (cnt >= LONG_LAST) begin
                    state_nxt = S_HELD;
                    cnt_nxt   = '0;
                    wr_en     = 1'b1;
                    wr_val    = DEF_IDX;
                end
            end
            S_HELD: begin
                if (!pr) begin
                    state_nxt = S_DB_REL;
                    cnt_nxt   = CNT_W'(1);
                    tag_nxt   = 1'b1;
                end
            end
            S_DB_REL: begin
                if (pr) begin
                    state_nxt = tag_long ? S_HELD : S_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt >= DBNC_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    if (!tag_long) begin
                        wr_en  = 1'b1;
                        wr_val = next_mode(mode);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            tag_long <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tag_long <= tag_nxt;
        end
    end

    // Stage p2: mode, its one-hot copy and the change strobe update together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= DEF_IDX;
            mode_oh  <= one_hot(DEF_IDX);
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= wr_en && (wr_val != mode);
            if (wr_en) begin
                mode    <= wr_val;
                mode_oh <= one_hot(wr_val);
            end
        end
    end

    assign long_act = (state == S_HELD);

endmodule

// File: tb/tb_mode_sel_multi.sv
// Scoreboard bench for mode_sel_multi: press-level model predicts each mode change and its cycle;
// a monitor process pops predictions on every mode_chg pulse.
module tb_mode_sel_multi;

    localparam int NM  = 5;
    localparam int DEF = 0;
    localparam int DB  = 4;
    localparam int LG  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic [2:0] mode;
    logic [4:0] mode_oh;
    logic       mode_chg;
    logic       long_act;

    mode_sel_multi #(
        .C_ON(1'b1), .NUM_MODES(NM), .DEF_MODE(DEF), .DBNC_CYCLES(DB), .LONG_CYCLES(LG)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .mode(mode), .mode_oh(mode_oh), .mode_chg(mode_chg), .long_act(long_act)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int m;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cur_exp = DEF;
    int   model_mode = DEF;
    int   la_start = 0;
    int   la_end = -1;
    bit   mon_en = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hold btn_in at v for n sampling edges, then settle 1 time unit after the last edge.
    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One press: held h cycles; optionally released r cycles then bounced high g cycles;
    // finally released l cycles. Expected effect is predicted from press/release timing.
    task automatic press(input int h, input int r, input int g, input int l);
        int   p;
        int   q;
        int   eff;
        int   nm;
        exp_t e;
        p = cyc + 1;
        q = p + h + ((r > 0) ? (r + g) : 0);
        eff = -1;
        nm = model_mode;
        if (h >= DB + LG && r == 0) begin
            eff = p + DB + 1 + LG;
            nm = DEF;
            la_start = eff;
            la_end = p + h + 1;
        end else if (h >= DB) begin
            eff = q + DB + 1;
            nm = (model_mode + 1) % NM;
        end
        if (eff >= 0 && nm != model_mode) begin
            e.at = eff;
            e.m = nm;
            sb.push_back(e);
        end
        model_mode = nm;
        drive(1'b1, h);
        if (r > 0) begin
            drive(1'b0, r);
            drive(1'b1, g);
        end
        drive(1'b0, l);
    endtask

    task automatic check_reset_state();
        check(mode == 3'd0, "rst_mode", int'(mode), 0);
        check(mode_oh == 5'b00001, "rst_mode_oh", int'(mode_oh), 1);
        check(mode_chg == 1'b0, "rst_mode_chg", int'(mode_chg), 0);
        check(long_act == 1'b0, "rst_long_act", int'(long_act), 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        bit   la_exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                cur_exp = DEF;
            end else if (mon_en) begin
                if (mode_chg) begin
                    check(sb.size() > 0, "chg_predicted", sb.size(), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check(cyc == e.at, "chg_cycle", cyc, e.at);
                        check(int'(mode) == e.m, "chg_mode", int'(mode), e.m);
                        cur_exp = e.m;
                    end
                end
                check(int'(mode) == cur_exp, "mode", int'(mode), cur_exp);
                check(mode_oh == (5'd1 << cur_exp), "mode_oh", int'(mode_oh), 1 << cur_exp);
                la_exp = (cyc >= la_start) && (cyc <= la_end);
                check(long_act == la_exp, "long_act", int'(long_act), int'(la_exp));
            end
        end
    end

    // Stimulus
    initial begin
        int op;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        repeat (5) press(10, 0, 0, 10);

        for (int g = 1; g < DB; g++) begin
            press(g, 0, 0, 10);
            press(10, 2, g, 12);
        end

        while (model_mode != 3) press(10, 0, 0, 10);
        press(40, 0, 0, 12);
        press(40, 0, 0, 12);

        press(DB + LG - 1, 0, 0, 12);
        press(DB + LG, 0, 0, 12);
        press(DB, 0, 0, 12);

        repeat (40) begin
            op = $urandom_range(0, 3);
            case (op)
                0: press($urandom_range(DB, DB + LG - 1), 0, 0, $urandom_range(10, 16));
                1: press($urandom_range(DB + LG, DB + LG + 12), 0, 0, $urandom_range(10, 16));
                2: press($urandom_range(1, DB - 1), 0, 0, $urandom_range(10, 16));
                default: press($urandom_range(DB, 14), $urandom_range(1, DB - 1),
                               $urandom_range(1, 3), $urandom_range(10, 16));
            endcase
        end

        if (model_mode == DEF) press(10, 0, 0, 10);
        btn_in = 1'b1;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        model_mode = DEF;
        repeat (3) @(posedge clk);
        #1 btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        repeat (30) @(posedge clk);
        #1;

        rst = 1'b0;
        btn_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        press(10, 0, 0, 12);

        repeat (20) @(posedge clk);
        #1;
        check(sb.size() == 0, "pending_changes", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
